// File: rtl/speed_meter_pkg.sv
// Shared types for the speed meter: FSM state encoding (doubles as the led code)
// and the divider numerator width helper.
package speed_meter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_ARMED  = 3'b001,
        ST_DIVIDE = 3'b010,
        ST_SHOW   = 3'b100
    } state_t;

    function automatic int num_width(input int dist_w, input int tick_hz);
        return dist_w + $clog2(tick_hz + 1);
    endfunction

endpackage

// File: rtl/udiv_seq.sv
// Restoring unsigned divider, one quotient bit per cycle; the numerator shifts out
// of the quotient register as quotient bits shift in.
module udiv_seq #(
    parameter int N_W = 18,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] num,
    input  logic [D_W-1:0] den,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quot,
    output logic           div0
);

    localparam int C_W = $clog2(N_W + 1);

    logic [D_W-1:0] den_r;
    logic [D_W-1:0] rem;
    logic [C_W-1:0] cnt;
    logic [D_W:0]   trial;

    assign trial = {rem, quot[N_W-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            den_r <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quot  <= num;
                rem   <= '0;
                den_r <= den;
                cnt   <= C_W'(N_W);
                div0  <= (den == '0);
                busy  <= (den != '0);
            end else if (busy) begin
                if (trial >= {1'b0, den_r}) begin
                    rem  <= D_W'(trial - {1'b0, den_r});
                    quot <= {quot[N_W-2:0], 1'b1};
                end else begin
                    rem  <= trial[D_W-1:0];
                    quot <= {quot[N_W-2:0], 1'b0};
                end
                cnt <= cnt - C_W'(1);
                if (cnt == C_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/speed_meter.sv
// Two-point speed measurement: debounced key captures, prescaled interval timer,
// |d2-d1|*TICK_HZ/ticks via sequential divider, manual or sliding-window auto mode.
module speed_meter
    import speed_meter_pkg::*;
#(
    parameter int DIST_W     = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 100,
    parameter int TIME_W     = 16,
    parameter int AUTO_TICKS = 50,
    parameter int DEB_CYC    = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key,
    input  logic              mode,
    input  logic [DIST_W-1:0] distance,
    output logic [2:0]        led,
    output logic [DIST_W-1:0] tube_data,
    output logic [DIST_W-1:0] speed,
    output logic              dir,
    output logic              speed_valid,
    output logic              err_time
);

    localparam int NUM_W   = num_width(DIST_W, TICK_HZ);
    localparam int PRE_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W   = $clog2(PRE_DIV);
    localparam int DEB_W   = $clog2(DEB_CYC + 1);

    state_t              state, state_next;
    logic                key_s1, key_s2, press;
    logic [DEB_W-1:0]    deb_cnt;
    logic [PRE_W-1:0]    presc;
    logic                tick;
    logic                mode_r;
    logic [DIST_W-1:0]   d1, d2, delta;
    logic [TIME_W-1:0]   elapsed;
    logic [NUM_W-1:0]    num, quot;
    logic                cap1, cap2, slide, finish;
    logic                div_busy, div_done, div0;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_W'(DEB_CYC)) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
                press   <= (deb_cnt == DEB_W'(DEB_CYC - 1));
            end
        end
    end

    assign tick = (presc == PRE_W'(PRE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || cap1 || cap2 || slide || tick) presc <= '0;
        else                                      presc <= presc + PRE_W'(1);
    end

    always_comb begin
        state_next = state;
        cap1       = 1'b0;
        cap2       = 1'b0;
        slide      = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: if (press) begin
                cap1       = 1'b1;
                state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (mode_r) begin
                    if (press) begin
                        state_next = ST_IDLE;
                    end else if (elapsed >= TIME_W'(AUTO_TICKS)) begin
                        cap2       = 1'b1;
                        state_next = ST_DIVIDE;
                    end
                end else if (press) begin
                    cap2       = 1'b1;
                    state_next = ST_DIVIDE;
                end
            end
            ST_DIVIDE: if (div0 || (div_done && !div_busy)) begin
                finish     = 1'b1;
                state_next = ST_SHOW;
            end
            ST_SHOW: begin
                if (press) begin
                    state_next = ST_IDLE;
                end else if (mode_r) begin
                    slide      = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Numerator comes from the live distance so the divider loads on the same edge that captures d2.
    always_comb begin
        delta = (distance >= d1) ? (distance - d1) : (d1 - distance);
        num   = NUM_W'(delta) * NUM_W'(TICK_HZ);
    end

    udiv_seq #(
        .N_W(NUM_W),
        .D_W(TIME_W)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .start(cap2),
        .num  (num),
        .den  (elapsed),
        .busy (div_busy),
        .done (div_done),
        .quot (quot),
        .div0 (div0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_r      <= 1'b0;
            d1          <= '0;
            d2          <= '0;
            elapsed     <= '0;
            speed       <= '0;
            dir         <= 1'b0;
            speed_valid <= 1'b0;
            err_time    <= 1'b0;
        end else begin
            state       <= state_next;
            speed_valid <= 1'b0;
            if (cap1) begin
                d1       <= distance;
                elapsed  <= '0;
                mode_r   <= mode;
                err_time <= 1'b0;
            end else if (slide) begin
                d1      <= d2;
                elapsed <= '0;
            end else if (state == ST_ARMED && tick && elapsed != '1) begin
                elapsed <= elapsed + TIME_W'(1);
            end
            if (cap2) d2 <= distance;
            if (finish) begin
                speed_valid <= 1'b1;
                dir         <= (d2 < d1);
                if (div0) begin
                    speed    <= '1;
                    err_time <= 1'b1;
                end else if (|quot[NUM_W-1:DIST_W]) begin
                    speed <= '1;
                end else begin
                    speed <= quot[DIST_W-1:0];
                end
            end
        end
    end

    assign led = state;

    always_comb begin
        case (state)
            ST_ARMED:  tube_data = d1;
            ST_DIVIDE: tube_data = d2;
            default:   tube_data = speed;
        endcase
    end

endmodule
